// File: rtl/fwrisc_bus_pkg.sv
// Shared types for the fwrisc memory-port arbiter: FSM states, requester ids
// and the request bundle that is muxed onto the memory bus.
package fwrisc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstb;
    } bus_req_t;

    // Bundles one requester's request fields into the bus struct.
    function automatic bus_req_t make_req(
        input logic [31:0] addr,
        input logic        write,
        input logic [31:0] wdata,
        input logic [3:0]  wstb
    );
        bus_req_t r;
        r.addr  = addr;
        r.write = write;
        r.wdata = wdata;
        r.wstb  = wstb;
        return r;
    endfunction

endpackage

// File: rtl/fwrisc_bus_arb_if.sv
// Simple valid/ready memory bus used on both the requester and memory sides
// of the arbiter; master issues requests, slave completes them.
interface fwrisc_bus_arb_if;
    logic [31:0] addr;
    logic        valid;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output addr, valid, write, wdata, wstb,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, valid, write, wdata, wstb,
        output rdata, ready, err
    );
endinterface

// File: rtl/fwrisc_bus_watchdog.sv
// Granted-cycle counter that flags a transfer which has waited too long for
// the memory; compiled away entirely when TIMEOUT_CYCLES is 0.
module fwrisc_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_s;
            assign unused_s = &{1'b0, clock, reset, start, run};
            assign expire   = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_r;

            // Counts stalled granted cycles; start wins so a completing cycle rearms it.
            always_ff @(posedge clock) begin
                if (reset) begin
                    count_r <= '0;
                end else if (start) begin
                    count_r <= '0;
                end else if (run) begin
                    count_r <= count_r + CW'(1'b1);
                end else begin
                    count_r <= count_r;
                end
            end

            assign expire = run && (count_r == LAST_COUNT);
        end
    endgenerate

endmodule

// File: rtl/fwrisc_bus_arb.sv
// Shares the single memory port between instruction fetch (I) and the data
// port (D); the grant is held for a whole transfer.
module fwrisc_bus_arb
    import fwrisc_bus_pkg::*;
#(
    parameter bit          D_PRIORITY     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                clock,
    input  logic                reset,
    fwrisc_bus_arb_if.slave     i_bus,
    fwrisc_bus_arb_if.slave     d_bus,
    fwrisc_bus_arb_if.master    m_bus
);

    arb_state_e state_r;
    logic       last_gnt_r;
    bus_req_t   i_req_s;
    bus_req_t   d_req_s;
    bus_req_t   sel_req_s;
    logic       gnt_s;
    logic       expire_s;
    logic       complete_s;
    logic       start_s;
    logic       run_s;
    logic       i_done_s;
    logic       d_done_s;
    logic       unused_s;

    // Fetches never write, so their write fields are forced to zero.
    always_comb begin
        i_req_s = make_req(i_bus.addr, 1'b0, 32'h0000_0000, 4'b0000);
        d_req_s = make_req(d_bus.addr, d_bus.write, d_bus.wdata, d_bus.wstb);
    end

    // Memory request mux follows the current grant.
    always_comb begin
        sel_req_s = '0;
        case (state_r)
            GNT_I:   sel_req_s = i_req_s;
            GNT_D:   sel_req_s = d_req_s;
            default: sel_req_s = '0;
        endcase
    end

    assign gnt_s      = (state_r != IDLE);
    assign complete_s = gnt_s && (m_bus.ready || expire_s);
    assign start_s    = !gnt_s || complete_s;
    assign run_s      = gnt_s && !m_bus.ready;

    fwrisc_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .start  (start_s),
        .run    (run_s),
        .expire (expire_s)
    );

    // A reset cycle abandons the transfer, so it must never produce a ready pulse.
    assign i_done_s = (state_r == GNT_I) && complete_s && !reset;
    assign d_done_s = (state_r == GNT_D) && complete_s && !reset;

    assign m_bus.valid = gnt_s;
    assign m_bus.addr  = sel_req_s.addr;
    assign m_bus.write = sel_req_s.write;
    assign m_bus.wdata = sel_req_s.wdata;
    assign m_bus.wstb  = sel_req_s.wstb;

    assign i_bus.ready = i_done_s;
    assign i_bus.err   = i_done_s && !m_bus.ready;
    assign i_bus.rdata = (i_done_s && m_bus.ready) ? m_bus.rdata : 32'h0000_0000;
    assign d_bus.ready = d_done_s;
    assign d_bus.err   = d_done_s && !m_bus.ready;
    assign d_bus.rdata = (d_done_s && m_bus.ready) ? m_bus.rdata : 32'h0000_0000;

    assign unused_s = &{1'b0, i_bus.write, i_bus.wdata, i_bus.wstb, m_bus.err};

    // Grant FSM: a completing requester hands over straight to a waiting peer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            last_gnt_r <= REQ_I;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_bus.valid && d_bus.valid) begin
                        state_r <= (D_PRIORITY || (last_gnt_r == REQ_I)) ? GNT_D : GNT_I;
                    end else if (d_bus.valid) begin
                        state_r <= GNT_D;
                    end else if (i_bus.valid) begin
                        state_r <= GNT_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_I: begin
                    if (complete_s) begin
                        last_gnt_r <= REQ_I;
                        state_r    <= d_bus.valid ? GNT_D : IDLE;
                    end else begin
                        state_r <= GNT_I;
                    end
                end
                GNT_D: begin
                    if (complete_s) begin
                        last_gnt_r <= REQ_D;
                        state_r    <= i_bus.valid ? GNT_I : IDLE;
                    end else begin
                        state_r <= GNT_D;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_bus_arb.sv
// Bench for fwrisc_bus_arb: env 0 uses D priority with a 4-cycle watchdog,
// env 1 uses round-robin with no watchdog.
module tb_fwrisc_bus_arb;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic        rst_v    [2];
    logic [31:0] iaddr_v  [2];
    logic        ivalid_v [2];
    logic [31:0] daddr_v  [2];
    logic        dvalid_v [2];
    logic        dwrite_v [2];
    logic [31:0] dwdata_v [2];
    logic [3:0]  dwstb_v  [2];
    logic [31:0] mrdata_v [2];
    logic        mready_v [2];
    logic [137:0] obs_w   [2];

    localparam logic [137:0] QUIET = '0;

    fwrisc_bus_arb_if i0 ();
    fwrisc_bus_arb_if d0 ();
    fwrisc_bus_arb_if m0 ();
    fwrisc_bus_arb_if i1 ();
    fwrisc_bus_arb_if d1 ();
    fwrisc_bus_arb_if m1 ();

    assign i0.addr = iaddr_v[0];  assign i0.valid = ivalid_v[0];
    assign i0.write = 1'b0;       assign i0.wdata = 32'h0;  assign i0.wstb = 4'h0;
    assign d0.addr = daddr_v[0];  assign d0.valid = dvalid_v[0];  assign d0.write = dwrite_v[0];
    assign d0.wdata = dwdata_v[0]; assign d0.wstb = dwstb_v[0];
    assign m0.rdata = mrdata_v[0]; assign m0.ready = mready_v[0]; assign m0.err = 1'b0;
    assign i1.addr = iaddr_v[1];  assign i1.valid = ivalid_v[1];
    assign i1.write = 1'b0;       assign i1.wdata = 32'h0;  assign i1.wstb = 4'h0;
    assign d1.addr = daddr_v[1];  assign d1.valid = dvalid_v[1];  assign d1.write = dwrite_v[1];
    assign d1.wdata = dwdata_v[1]; assign d1.wstb = dwstb_v[1];
    assign m1.rdata = mrdata_v[1]; assign m1.ready = mready_v[1]; assign m1.err = 1'b0;

    assign obs_w[0] = {m0.valid, m0.write, m0.wstb, m0.addr, m0.wdata,
                       i0.ready, i0.err, i0.rdata, d0.ready, d0.err, d0.rdata};
    assign obs_w[1] = {m1.valid, m1.write, m1.wstb, m1.addr, m1.wdata,
                       i1.ready, i1.err, i1.rdata, d1.ready, d1.err, d1.rdata};

    fwrisc_bus_arb #(.D_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) u_dut0 (
        .clock(clock), .reset(rst_v[0]), .i_bus(i0), .d_bus(d0), .m_bus(m0));
    fwrisc_bus_arb #(.D_PRIORITY(1'b0), .TIMEOUT_CYCLES(0)) u_dut1 (
        .clock(clock), .reset(rst_v[1]), .i_bus(i1), .d_bus(d1), .m_bus(m1));

    // Observation vector: {mvalid, mwrite, mwstb, maddr, mwdata, iready, ierr, irdata, dready, derr, drdata}
    function automatic logic [137:0] mk(input logic mv, input logic mw, input logic [3:0] ms,
                                        input logic [31:0] ma, input logic [31:0] mwd,
                                        input logic ir, input logic ie, input logic [31:0] ird,
                                        input logic dr, input logic de, input logic [31:0] drd);
        return {mv, mw, ms, ma, mwd, ir, ie, ird, dr, de, drd};
    endfunction

    // Address and write data are don't-care while no request is on the bus.
    function automatic logic [137:0] masked(input logic [137:0] got, input logic [137:0] exp);
        logic [137:0] r;
        r = got;
        if (!exp[137]) r[131:68] = 64'h0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic clear_inputs(input int e);
        ivalid_v[e] = 1'b0; iaddr_v[e] = 32'h0;
        dvalid_v[e] = 1'b0; daddr_v[e] = 32'h0; dwrite_v[e] = 1'b0;
        dwdata_v[e] = 32'h0; dwstb_v[e] = 4'h0;
        mready_v[e] = 1'b0; mrdata_v[e] = 32'h0;
    endtask

    task automatic do_reset(input int e);
        tick();
        clear_inputs(e);
        rst_v[e] = 1'b1;
        tick();
        tick();
        rst_v[e] = 1'b0;
    endtask

    task automatic test_reset(input int e);
        do_reset(e);
        tick();
        rst_v[e] = 1'b1; ivalid_v[e] = 1'b1; dvalid_v[e] = 1'b1;
        mready_v[e] = 1'b1; mrdata_v[e] = 32'h1234_5678;
        tick();
        settle();
        if (masked(obs_w[e], QUIET) !== QUIET) begin
            fails++;
            $display("FAIL reset e%0d: got %h expected %h", e, obs_w[e], QUIET);
        end
        tests++;
        clear_inputs(e);
        rst_v[e] = 1'b0;
    endtask

    task automatic test_i_only();
        logic [137:0] exp [5];
        exp = '{QUIET,
                mk(1'b1, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 32'h0),
                QUIET};
        do_reset(0);
        for (int c = 0; c < 5; c++) begin
            tick();
            ivalid_v[0] = (c < 4); iaddr_v[0] = 32'h8000_0000;
            mready_v[0] = (c == 3); mrdata_v[0] = (c == 3) ? 32'h0000_0013 : 32'h0;
            settle();
            if (masked(obs_w[0], exp[c]) !== exp[c]) begin
                fails++;
                $display("FAIL i_only c%0d: got %h expected %h", c, obs_w[0], exp[c]);
            end
            tests++;
        end
    endtask

    task automatic test_d_store();
        logic [137:0] exp [4];
        exp = '{QUIET,
                mk(1'b1, 1'b1, 4'b0011, 32'h1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b1, 4'b0011, 32'h1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h55),
                QUIET};
        do_reset(0);
        for (int c = 0; c < 4; c++) begin
            tick();
            dvalid_v[0] = (c < 3); daddr_v[0] = 32'h1000; dwrite_v[0] = 1'b1;
            dwdata_v[0] = 32'hDEAD_BEEF; dwstb_v[0] = 4'b0011;
            mready_v[0] = (c == 2); mrdata_v[0] = (c == 2) ? 32'h55 : 32'h0;
            settle();
            if (masked(obs_w[0], exp[c]) !== exp[c]) begin
                fails++;
                $display("FAIL d_store c%0d: got %h expected %h", c, obs_w[0], exp[c]);
            end
            tests++;
        end
    endtask

    task automatic test_tie_priority();
        logic [137:0] exp [5];
        exp = '{QUIET,
                mk(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hAA),
                mk(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hBB, 1'b0, 1'b0, 32'h0),
                QUIET};
        do_reset(0);
        for (int c = 0; c < 5; c++) begin
            tick();
            ivalid_v[0] = (c < 4); iaddr_v[0] = 32'h100;
            dvalid_v[0] = (c < 2); daddr_v[0] = 32'h200; dwstb_v[0] = 4'hF;
            mready_v[0] = (c == 1) || (c == 3);
            mrdata_v[0] = (c == 1) ? 32'hAA : 32'hBB;
            settle();
            if (masked(obs_w[0], exp[c]) !== exp[c]) begin
                fails++;
                $display("FAIL tie_priority c%0d: got %h expected %h", c, obs_w[0], exp[c]);
            end
            tests++;
        end
    endtask

    task automatic test_round_robin();
        logic [137:0] exp [9];
        exp = '{QUIET,
                mk(1'b1, 1'b0, 4'hF, 32'h200, 32'h11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC1),
                QUIET,
                QUIET,
                mk(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hC4, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b0, 4'hF, 32'h200, 32'h11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC5),
                mk(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hC6, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b0, 4'hF, 32'h200, 32'h11, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC7),
                QUIET};
        do_reset(1);
        for (int c = 0; c < 9; c++) begin
            tick();
            dvalid_v[1] = (c <= 1) || (c >= 3 && c <= 7); daddr_v[1] = 32'h200;
            dwdata_v[1] = 32'h11; dwstb_v[1] = 4'hF;
            ivalid_v[1] = (c >= 3 && c <= 6); iaddr_v[1] = 32'h100;
            mready_v[1] = (c == 1) || (c >= 3 && c <= 7);
            mrdata_v[1] = 32'hC0 + 32'(c);
            settle();
            if (masked(obs_w[1], exp[c]) !== exp[c]) begin
                fails++;
                $display("FAIL round_robin c%0d: got %h expected %h", c, obs_w[1], exp[c]);
            end
            tests++;
        end
    endtask

    task automatic test_timeout();
        logic [137:0] exp [13];
        logic [137:0] wait_v;
        wait_v = mk(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp = '{QUIET, wait_v, wait_v, wait_v,
                mk(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0),
                QUIET, QUIET, QUIET, wait_v, wait_v, wait_v,
                mk(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hABCD),
                QUIET};
        do_reset(0);
        for (int c = 0; c < 13; c++) begin
            tick();
            dvalid_v[0] = (c <= 4) || (c >= 7 && c <= 11); daddr_v[0] = 32'h300; dwstb_v[0] = 4'hF;
            mready_v[0] = (c == 5) || (c == 11); mrdata_v[0] = 32'hABCD;
            settle();
            if (masked(obs_w[0], exp[c]) !== exp[c]) begin
                fails++;
                $display("FAIL timeout c%0d: got %h expected %h", c, obs_w[0], exp[c]);
            end
            tests++;
        end
    endtask

    task automatic test_reset_mid();
        logic [137:0] exp [6];
        exp = '{QUIET,
                mk(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                mk(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0),
                QUIET,
                mk(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 32'h0),
                QUIET};
        do_reset(0);
        for (int c = 0; c < 6; c++) begin
            tick();
            rst_v[0] = (c == 2);
            ivalid_v[0] = (c < 5); iaddr_v[0] = 32'h400;
            mready_v[0] = (c == 4); mrdata_v[0] = 32'h77;
            settle();
            if (masked(obs_w[0], exp[c]) !== exp[c]) begin
                fails++;
                $display("FAIL reset_mid c%0d: got %h expected %h", c, obs_w[0], exp[c]);
            end
            tests++;
        end
    endtask

    // Reference: who owns the port (0 none, 1 I, 2 D), who was served last, granted-cycle age.
    task automatic test_random(input int e, input int ncycles);
        int owner; int last; int age; int limit; bit dprio;
        logic done; logic ir; logic dr; logic idone; logic ddone;
        logic [137:0] exp;
        owner = 0; last = 1; age = 0; idone = 1'b0; ddone = 1'b0;
        limit = (e == 0) ? 4 : 0;
        dprio = (e == 0);
        do_reset(e);
        for (int c = 0; c < ncycles; c++) begin
            tick();
            if (!ivalid_v[e] || idone) begin
                ivalid_v[e] = ($urandom_range(0, 2) == 0);
                iaddr_v[e]  = $urandom;
            end
            if (!dvalid_v[e] || ddone) begin
                dvalid_v[e] = ($urandom_range(0, 2) == 0);
                daddr_v[e]  = $urandom;
                dwrite_v[e] = $urandom_range(0, 1) == 1;
                dwdata_v[e] = $urandom;
                dwstb_v[e]  = 4'($urandom);
            end
            mready_v[e] = ($urandom_range(0, 2) == 0);
            mrdata_v[e] = $urandom;
            settle();
            done = (owner != 0) && (mready_v[e] || (limit > 0 && age == limit - 1));
            ir = (owner == 1) && done;
            dr = (owner == 2) && done;
            exp = mk(owner != 0,
                     (owner == 2) ? dwrite_v[e] : 1'b0,
                     (owner == 2) ? dwstb_v[e] : 4'h0,
                     (owner == 1) ? iaddr_v[e] : ((owner == 2) ? daddr_v[e] : 32'h0),
                     (owner == 2) ? dwdata_v[e] : 32'h0,
                     ir, ir && !mready_v[e], (ir && mready_v[e]) ? mrdata_v[e] : 32'h0,
                     dr, dr && !mready_v[e], (dr && mready_v[e]) ? mrdata_v[e] : 32'h0);
            if (masked(obs_w[e], exp) !== exp) begin
                fails++;
                $display("FAIL random e%0d c%0d: got %h expected %h", e, c, obs_w[e], exp);
            end
            tests++;
            idone = ir;
            ddone = dr;
            if (owner == 0) begin
                if (ivalid_v[e] && dvalid_v[e]) owner = (dprio || last == 1) ? 2 : 1;
                else if (dvalid_v[e])            owner = 2;
                else if (ivalid_v[e])            owner = 1;
                age = 0;
            end else if (done) begin
                last = owner;
                if (owner == 1 && dvalid_v[e])      owner = 2;
                else if (owner == 2 && ivalid_v[e]) owner = 1;
                else                                owner = 0;
                age = 0;
            end else begin
                age++;
            end
        end
    endtask

    initial begin
        for (int e = 0; e < 2; e++) begin
            rst_v[e] = 1'b1;
            clear_inputs(e);
        end
        test_reset(0);
        test_reset(1);
        test_i_only();
        test_d_store();
        test_tie_priority();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random(0, 400);
        test_random(1, 400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
